// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master shared-bus arbiter.
// Holds the arbiter state encoding, master index type and round-robin pick helper.
package bus_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned DATA_W          = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef logic master_idx_t;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  // On a tie the master that was not served last wins.
  function automatic master_idx_t pick_master(input logic req0, input logic req1,
                                              input master_idx_t last);
    if (req0 && req1) return ~last;
    if (req1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned timer_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Transaction watchdog: counts BUSY cycles, flags the last allowed cycle.
// Synchronous clear has priority over enable; the count holds at terminal.
module bus_timer import bus_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned   W    = timer_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for one shared memory bus; strobe one cycle after request.
// Masters hold requests until ready/error; slave stalls bounded by TIMEOUT_CYCLES then error.
module bus_arbiter import bus_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  output logic              m0_error,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              m1_error,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready
);

  arb_state_t  state, state_nxt;
  master_idx_t grant, grant_nxt;
  master_idx_t last_grant, last_grant_nxt;

  mreq_t req0, req1, sel;
  logic  req0_any, req1_any;
  logic  timer_clear, timer_en, timeout;
  logic  done_ok, done_err;

  assign req0     = '{read: m0_read, write: m0_write, addr: m0_addr, wdata: m0_wdata};
  assign req1     = '{read: m1_read, write: m1_write, addr: m1_addr, wdata: m1_wdata};
  assign req0_any = m0_read || m0_write;
  assign req1_any = m1_read || m1_write;
  assign sel      = (grant == 1'b1) ? req1 : req0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (timeout)
  );

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    timer_clear    = 1'b0;
    timer_en       = 1'b0;
    done_ok        = 1'b0;
    done_err       = 1'b0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_addr         = '0;
    s_wdata        = '0;

    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (req0_any || req1_any) begin
          grant_nxt = pick_master(req0_any, req1_any, last_grant);
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        timer_en = 1'b1;
        if (sel.read && sel.write) begin
          done_err       = 1'b1;
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end else if (!sel.read && !sel.write) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end else begin
          // The strobe stays up through the terminal cycle so a late s_ready still completes.
          s_read  = sel.read;
          s_write = sel.write;
          s_addr  = sel.addr;
          s_wdata = sel.wdata;
          if (s_ready) begin
            done_ok        = 1'b1;
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end else if (timeout) begin
            done_err       = 1'b1;
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    m0_ready = done_ok  && (grant == 1'b0);
    m1_ready = done_ok  && (grant == 1'b1);
    m0_error = done_err && (grant == 1'b0);
    m1_error = done_err && (grant == 1'b1);
    m0_rdata = m0_ready ? s_rdata : '0;
    m1_rdata = m1_ready ? s_rdata : '0;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter against a cycle-level transaction model.
module tb_bus_arbiter;

  localparam int TO   = 16;
  localparam int NCYC = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mrd [2];
  logic        mwr [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_error, m1_ready, m1_error;
  logic        s_read, s_write;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mode   = 0;

  // Reference model: owner of the bus (-1 = none), BUSY cycles elapsed, last served master.
  int owner = -1;
  int age   = 0;
  int last  = 1;
  bit active [2];
  bit done [2];

  bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_read  (mrd[0]),
    .m0_write (mwr[0]),
    .m0_addr  (maddr[0]),
    .m0_wdata (mwd[0]),
    .m0_rdata (m0_rdata),
    .m0_ready (m0_ready),
    .m0_error (m0_error),
    .m1_read  (mrd[1]),
    .m1_write (mwr[1]),
    .m1_addr  (maddr[1]),
    .m1_wdata (mwd[1]),
    .m1_rdata (m1_rdata),
    .m1_ready (m1_ready),
    .m1_error (m1_error),
    .s_read   (s_read),
    .s_write  (s_write),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_inputs();
    int op;
    rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
    for (int i = 0; i < 2; i++) begin
      if (done[i]) begin
        active[i] = 1'b0;
      end else if (active[i] && $urandom_range(0, 59) == 0) begin
        active[i] = 1'b0;
      end else if (!active[i] && $urandom_range(0, 2) == 0) begin
        active[i] = 1'b1;
        op        = $urandom_range(0, 11);
        mrd[i]    = (op <= 5) || (op == 11);
        mwr[i]    = (op > 5);
        maddr[i]  = $urandom;
        mwd[i]    = $urandom;
      end
      if (!active[i]) begin
        mrd[i] = 1'b0;
        mwr[i] = 1'b0;
      end
    end
    mode = (cyc / 250) % 4;
    case (mode)
      0:       s_ready = ($urandom_range(0, 3) == 0);
      1:       s_ready = 1'b0;
      2:       s_ready = (owner >= 0) && (age == TO - 1);
      default: s_ready = ($urandom_range(0, 1) == 0);
    endcase
    if (rst) s_ready = 1'b0;
    s_rdata = $urandom;
  endtask

  task automatic model_step();
    logic        e_sr, e_sw;
    logic [31:0] e_sa, e_swd;
    logic        e_rdy [2];
    logic        e_err [2];
    logic [31:0] e_rd [2];
    bit          fin;
    bit          want0, want1;
    e_sr  = 1'b0;
    e_sw  = 1'b0;
    e_sa  = '0;
    e_swd = '0;
    fin   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_rdy[i] = 1'b0;
      e_err[i] = 1'b0;
      e_rd[i]  = '0;
    end

    if (owner >= 0) begin
      if (mrd[owner] && mwr[owner]) begin
        e_err[owner] = 1'b1;
        fin          = 1'b1;
      end else if (!mrd[owner] && !mwr[owner]) begin
        fin = 1'b1;
      end else begin
        e_sr  = mrd[owner];
        e_sw  = mwr[owner];
        e_sa  = maddr[owner];
        e_swd = mwd[owner];
        if (s_ready) begin
          e_rdy[owner] = 1'b1;
          e_rd[owner]  = s_rdata;
          fin          = 1'b1;
        end else if (age == TO - 1) begin
          e_err[owner] = 1'b1;
          fin          = 1'b1;
        end
      end
    end

    chk_val("s_read",   32'(s_read),   32'(e_sr));
    chk_val("s_write",  32'(s_write),  32'(e_sw));
    chk_val("s_addr",   s_addr,        e_sa);
    chk_val("s_wdata",  s_wdata,       e_swd);
    chk_val("m0_ready", 32'(m0_ready), 32'(e_rdy[0]));
    chk_val("m0_error", 32'(m0_error), 32'(e_err[0]));
    chk_val("m0_rdata", m0_rdata,      e_rd[0]);
    chk_val("m1_ready", 32'(m1_ready), 32'(e_rdy[1]));
    chk_val("m1_error", 32'(m1_error), 32'(e_err[1]));
    chk_val("m1_rdata", m1_rdata,      e_rd[1]);

    for (int i = 0; i < 2; i++) done[i] = e_rdy[i] || e_err[i];

    want0 = mrd[0] || mwr[0];
    want1 = mrd[1] || mwr[1];
    if (rst) begin
      owner = -1;
      age   = 0;
      last  = 1;
    end else if (owner < 0) begin
      if (want0 && want1) owner = 1 - last;
      else if (want0)     owner = 0;
      else if (want1)     owner = 1;
      age = 0;
    end else if (fin) begin
      last  = owner;
      owner = -1;
    end else begin
      age++;
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_ready = 1'b0;
    s_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      mrd[i]    = 1'b0;
      mwr[i]    = 1'b0;
      maddr[i]  = '0;
      mwd[i]    = '0;
      active[i] = 1'b0;
      done[i]   = 1'b0;
    end
    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      @(posedge clk);
      #1;
      drive_inputs();
      @(negedge clk);
      model_step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
